// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_cipher_pkg
// Description : Shared types and constants for the XOR stream cipher.
//               - state_t      : burst controller states (IDLE, RUN, FLUSH)
//               - MODE_FIXED   : keystream is the key itself, never changes
//               - MODE_LFSR    : keystream is a Galois LFSR seeded by the key
//               - DEFAULT_POLY : default Galois feedback taps (CRC-32 poly)
// Revision    : 1.0 - initial release
// ============================================================================
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_LFSR  = 1'b1;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

endpackage
`default_nettype wire

// File: rtl/xor_keystream_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : xor_keystream_lfsr
// Description : Keystream register. Loaded with the seed at burst start and,
//               in LFSR mode, stepped once per accepted word (Galois form).
//               In fixed mode the seed is held unchanged.
// Ports       : clk, rst      - clock / synchronous active-high reset
//               load, seed    - capture seed into the keystream register
//               advance       - one accepted word; steps the LFSR in LFSR mode
//               mode          - MODE_FIXED or MODE_LFSR
//               ks            - current keystream word
// Revision    : 1.0 - initial release
// ============================================================================
module xor_keystream_lfsr
    import xor_cipher_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  LFSR_POLY = DATA_W'(DEFAULT_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    input  logic              mode,
    output logic [DATA_W-1:0] ks
);

    logic [DATA_W-1:0] r_ks;
    logic [DATA_W-1:0] w_ks_step;

    // Multiply-by-x modulo the feedback polynomial. A zero seed is a fixed
    // point, so a zero key yields a zero keystream (plain pass-through).
    assign w_ks_step = {r_ks[DATA_W-2:0], 1'b0} ^ (r_ks[DATA_W-1] ? LFSR_POLY : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ks <= '0;
        end else if (load) begin
            r_ks <= seed;
        end else if (advance && (mode == MODE_LFSR)) begin
            r_ks <= w_ks_step;
        end
    end

    assign ks = r_ks;

endmodule
`default_nettype wire

// File: rtl/xor_stream_cipher.sv
`default_nettype none
// ============================================================================
// Module      : xor_stream_cipher
// Description : Burst XOR encryptor/decryptor with valid/ready streams.
//               cfg_start launches a burst of cfg_len words; each accepted
//               word is XORed with the keystream and presented one cycle
//               later on the output register. done pulses once per burst.
// Ports       : clk, rst                        - clock / sync active-high reset
//               cfg_start, cfg_key, cfg_len,
//               cfg_mode                        - burst configuration
//               busy                            - burst in progress
//               in_valid, in_data, in_ready     - input stream
//               out_valid, out_data, out_ready  - output stream
//               done                            - one-cycle burst-complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  LFSR_POLY = DATA_W'(DEFAULT_POLY),
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [DATA_W-1:0] cfg_key,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              cfg_mode,
    output logic              busy,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              done
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_done_next;
    logic              r_done;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_mode;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_ks;
    logic              w_start;
    logic              w_load;
    logic              w_accept;
    logic              w_out_take;

    // Start requests only count in IDLE; a zero-length burst never leaves IDLE.
    assign w_start    = cfg_start && (r_state == IDLE);
    assign w_load     = w_start && (cfg_len != '0);
    assign w_out_take = r_out_valid && out_ready;

    // Accept only when the output register is empty or being drained this
    // cycle, so a handshake and a new accept can overlap with no bubble.
    assign in_ready = (r_state == RUN) && (r_remaining != '0) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (cfg_len != '0) begin
                        w_state_next = RUN;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_accept && (r_remaining == CNT_W'(1))) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_out_take) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_mode      <= MODE_FIXED;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_load) begin
                r_remaining <= cfg_len;
                r_mode      <= cfg_mode;
            end else if (w_accept) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end

            if (w_accept) begin
                r_out_data  <= in_data ^ w_ks;
                r_out_valid <= 1'b1;
            end else if (w_out_take) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    xor_keystream_lfsr #(
        .DATA_W    (DATA_W),
        .LFSR_POLY (LFSR_POLY)
    ) u_keystream (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .seed    (cfg_key),
        .advance (w_accept),
        .mode    (r_mode),
        .ks      (w_ks)
    );

    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_cipher.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_stream_cipher
// Description : Self-checking bench for xor_stream_cipher. A reference model
//               predicts every output word as in_data XOR keystream[k], where
//               keystream[k] is the key multiplied by x^k in GF(2)[x] modulo
//               the feedback polynomial (mode 1) or the key itself (mode 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_stream_cipher;

    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] POLY   = 32'h04C11DB7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [DATA_W-1:0] cfg_key;
    logic [CNT_W-1:0]  cfg_len;
    logic              cfg_mode;
    logic              busy;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              done;

    xor_stream_cipher #(
        .DATA_W    (DATA_W),
        .LFSR_POLY (POLY),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_key   (cfg_key),
        .cfg_len   (cfg_len),
        .cfg_mode  (cfg_mode),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Keystream word k: key * x^k mod P(x) over GF(2), computed one degree at a time.
    function automatic logic [DATA_W-1:0] ks_at(input logic [DATA_W-1:0] key, input bit mode, input int k);
        logic [DATA_W-1:0] v;
        v = key;
        if (mode) begin
            for (int i = 0; i < k; i++) begin
                if (v[DATA_W-1]) v = (v << 1) ^ POLY;
                else             v = v << 1;
            end
        end
        return v;
    endfunction

    // Model state for the current burst
    logic [DATA_W-1:0] m_key;
    bit                m_mode;
    int                m_idx;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] out_log[$];
    int                out_cnt = 0;

    // Compare process: all observations on the falling edge.
    bit                prev_acc = 0;
    bit                held_v   = 0;
    logic [DATA_W-1:0] held_d;
    logic [DATA_W-1:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_acc = 0;
            held_v   = 0;
        end else begin
            if (prev_acc) chk("latency_out_valid", 32'(out_valid), 32'd1);
            if (held_v) begin
                chk("hold_data", out_data, held_d);
                chk("hold_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 32'd0);
            if (!busy) chk("in_ready_idle", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("out_data", out_data, exp_w);
                end
                out_log.push_back(out_data);
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data ^ ks_at(m_key, m_mode, m_idx));
                m_idx++;
            end
            if (done) begin
                chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
                chk("done_not_busy", 32'(busy), 32'd0);
            end
            prev_acc = in_valid && in_ready;
            held_v   = out_valid && !out_ready;
            held_d   = out_data;
        end
    end

    logic [DATA_W-1:0] data_src [0:63];

    // Runs one burst. vpct/rpct: percentage of cycles with in_valid/out_ready.
    // stall3: out_ready held low until the first output, then 3 more cycles.
    // noise: spurious cfg_start pulses with other settings while busy.
    task automatic run_burst(input logic [DATA_W-1:0] key, input int len, input bit mode,
                             input int vpct, input int rpct, input bit stall3, input bit noise);
        int  sent = 0;
        int  dcnt = 0;
        int  cyc  = 0;
        int  base;
        int  budget;
        bit  seen_first = 0;
        int  stall_left = 0;
        budget = 200 + len * 40;
        @(posedge clk); #1;
        m_key  = key;
        m_mode = mode;
        m_idx  = 0;
        base   = out_cnt;
        cfg_key   = key;
        cfg_len   = CNT_W'(len);
        cfg_mode  = mode;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        while (!(sent >= len && dcnt > 0) && cyc < budget) begin
            in_valid = (sent < len) && (($urandom % 100) < vpct);
            in_data  = (sent < len) ? data_src[sent] : $urandom;
            if (stall3) begin
                if (!seen_first) out_ready = 1'b0;
                else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
                else out_ready = 1'b1;
            end else begin
                out_ready = (($urandom % 100) < rpct);
            end
            if (noise && sent < len && ($urandom % 6) == 0) begin
                cfg_start = 1'b1;
                cfg_key   = $urandom;
                cfg_len   = CNT_W'($urandom_range(1, 9));
                cfg_mode  = $urandom % 2;
            end else begin
                cfg_start = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (done) dcnt++;
            if (stall3 && !seen_first && out_valid) begin
                seen_first = 1;
                stall_left = 3;
            end
            @(posedge clk); #1;
            cyc++;
        end
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= budget) chk("burst_timeout", 32'(cyc), 32'(budget - 1));
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("done_count", 32'(dcnt), 32'd1);
        chk("words_out", 32'(out_cnt - base), 32'(len));
    endtask

    initial begin
        int base;
        int cyc;
        logic [DATA_W-1:0] ct [0:2];
        rst = 1'b1; cfg_start = 0; cfg_key = 0; cfg_len = 0; cfg_mode = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_done",      32'(done),      32'd0);

        // Fixed key, single word
        data_src[0] = 32'h12345678;
        out_log.delete();
        run_burst(32'hA5A5A5A5, 1, 1'b0, 100, 100, 0, 0);
        chk("t1_count", 32'(out_log.size()), 32'd1);
        if (out_log.size() >= 1) chk("t1_word", out_log[0], 32'hB791F3DD);

        // LFSR keystream from 0x80000000 over zeros
        for (int i = 0; i < 3; i++) data_src[i] = '0;
        out_log.delete();
        run_burst(32'h80000000, 3, 1'b1, 100, 100, 0, 0);
        chk("t2_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() >= 3) begin
            chk("t2_w0", out_log[0], 32'h80000000);
            chk("t2_w1", out_log[1], 32'h04C11DB7);
            chk("t2_w2", out_log[2], 32'h09823B6E);
            for (int i = 0; i < 3; i++) ct[i] = out_log[i];
        end else begin
            for (int i = 0; i < 3; i++) ct[i] = '1;
        end

        // Round trip: ciphertext back through the same key gives plaintext
        for (int i = 0; i < 3; i++) data_src[i] = ct[i];
        out_log.delete();
        run_burst(32'h80000000, 3, 1'b1, 100, 100, 0, 0);
        if (out_log.size() >= 3)
            for (int i = 0; i < 3; i++) chk("t3_roundtrip", out_log[i], 32'd0);
        else
            chk("t3_count", 32'(out_log.size()), 32'd3);

        // Output stall after first word, fixed key
        for (int i = 0; i < 4; i++) data_src[i] = $urandom;
        run_burst($urandom, 4, 1'b0, 100, 100, 1, 0);

        // Input gaps in LFSR mode must not advance the keystream
        for (int i = 0; i < 8; i++) data_src[i] = $urandom;
        run_burst($urandom, 8, 1'b1, 40, 100, 0, 0);

        // Zero-length burst
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_len = '0; cfg_key = $urandom; cfg_mode = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("len0_done",      32'(done),      32'd1);
        chk("len0_busy",      32'(busy),      32'd0);
        chk("len0_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("len0_done_off",  32'(done),      32'd0);
        chk("len0_busy2",     32'(busy),      32'd0);

        // LFSR mode with zero key is a pass-through
        data_src[0] = 32'hDEADBEEF;
        data_src[1] = 32'h0BADF00D;
        out_log.delete();
        run_burst(32'h0, 2, 1'b1, 100, 100, 0, 0);
        if (out_log.size() >= 2) begin
            chk("key0_w0", out_log[0], 32'hDEADBEEF);
            chk("key0_w1", out_log[1], 32'h0BADF00D);
        end else begin
            chk("key0_count", 32'(out_log.size()), 32'd2);
        end

        // Reset in the middle of a 4-word burst
        @(posedge clk); #1;
        m_key = 32'h13579BDF; m_mode = 1'b1; m_idx = 0;
        base = out_cnt;
        cfg_key = 32'h13579BDF; cfg_len = CNT_W'(4); cfg_mode = 1'b1; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
        cyc = 0;
        while (out_cnt < base + 2 && cyc < 50) begin
            @(posedge clk); #1;
            in_data = $urandom;
            cyc++;
        end
        if (cyc >= 50) chk("rst_mid_timeout", 32'(cyc), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy",      32'(busy),      32'd0);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_done",      32'(done),      32'd0);
        for (int i = 0; i < 4; i++) data_src[i] = $urandom;
        run_burst(32'h2468ACE1, 4, 1'b1, 100, 100, 0, 0);

        // Randomized bursts with backpressure, gaps and ignored restarts
        for (int b = 0; b < 25; b++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) data_src[i] = $urandom;
            run_burst($urandom, len, bit'($urandom % 2), $urandom_range(30, 100),
                      $urandom_range(30, 100), 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
- Parametrised successor to the single-shot 32-bit XOR encryptor.
- Encrypts or decrypts a burst of cfg_len words at one word per cycle.
- Input and output use valid/ready streams, so the block sits between a producer (DMA or bus bridge) and a consumer with backpressure.
- Two modes: fixed key (plain XOR) or rolling keystream from a Galois LFSR seeded by the key. Decryption is the same operation with the same key and mode.

Parameters:
- DATA_W, 32, word and key width (>=8).
- LFSR_POLY, 32'h04C11DB7, Galois feedback taps, DATA_W bits wide.
- CNT_W, 16, width of the burst-length counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle pulse that starts a burst.
- cfg_key  in  DATA_W  key / LFSR seed, sampled at start.
- cfg_len  in  CNT_W  number of words in the burst, sampled at start.
- cfg_mode  in  1  0 = fixed key, 1 = LFSR keystream; sampled at start.
- busy  out  1  high while state != IDLE.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  plaintext or ciphertext in.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_W  result word.
- out_ready  in  1  consumer accepts out_data.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: one clock, synchronous, active-high. Applying rst on any rising edge forces:
  - state=IDLE, busy=0, in_ready=0, out_valid=0, out_data=0, done=0, key/ks=0, remaining=0.
  - A burst in flight is abandoned; any held output word is dropped.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - cfg_start with cfg_len!=0: latch key into ks, latch len into remaining, latch mode; go to RUN next cycle.
  - cfg_start with cfg_len==0: done=1 on the next cycle; state stays IDLE; no words transferred.
- cfg_start while busy: ignored, no effect on the current burst.
- in_ready (combinational):
  - in_ready = (state==RUN) && (remaining!=0) && (!out_valid || out_ready).
- Accept event (in_valid && in_ready):
  - out_data <= in_data ^ ks; out_valid <= 1; remaining <= remaining-1.
  - Latency: 1 cycle from accept to out_valid.
  - Throughput: 1 word/cycle when out_ready is held high.
- Keystream:
  - mode 0: ks never changes.
  - mode 1: ks advances only on an accept event: ks <= {ks[DATA_W-2:0],1'b0} ^ (ks[DATA_W-1] ? LFSR_POLY : 0).
  - A stalled input does not advance ks.
  - mode 1 with key 0: ks stays 0 and data passes through unmodified. No substitution is made; this is documented behaviour.
- Output register:
  - out_valid && out_ready with no new accept in the same cycle: out_valid <= 0.
  - While out_valid && !out_ready: out_data and out_valid hold stable.
- RUN -> FLUSH: on the accept of the final word (remaining==1).
- FLUSH:
  - Wait for out_valid && out_ready.
  - On that cycle: done <= 1 (pulse on the next cycle) and state <= IDLE.
- done is high for exactly one cycle per burst. A new cfg_start in the cycle done is high is accepted, because state is already IDLE.
- Simultaneous output handshake and new accept in RUN: out_data is replaced and out_valid stays 1, with no bubble.
- remaining wraps never: in_ready is forced low at 0. Maximum burst is 2^CNT_W-1 words.

Decomposition:
- Package xor_cipher_pkg holds:
  - state enum {IDLE, RUN, FLUSH};
  - mode constants MODE_FIXED=0, MODE_LFSR=1;
  - default polynomial constant.
- Sub-module xor_keystream_lfsr (ports: clk, rst, load, seed, advance, mode, ks) encapsulates seed/advance logic.
- The top level owns the FSM, counter and output register.

Test Plan:
- mode0, key=0xA5A5A5A5, len=1, in_data=0x12345678, out_ready=1 -> out_data=0xB791F3DD one cycle after accept; done pulses one cycle after the output handshake.
- mode1, key=0x80000000, len=3, in_data=0 x3 back-to-back -> out_data=0x80000000, 0x04C11DB7, 0x09823B6E on consecutive cycles; done once.
- Same mode1 burst, then re-run with ciphertext as input and same key -> outputs all 0 (round trip).
- mode0, len=4, out_ready low for 3 cycles after the first output -> in_ready=0 during the stall, out_data stable, no words lost; in_valid gaps do not advance ks in mode1.
- cfg_len=0 -> done=1 exactly one cycle after start, out_valid never asserted, busy stays 0.
- rst asserted mid-burst (after word 2 of 4) -> next cycle busy=0, out_valid=0, done=0; a new burst then runs normally from the freshly sampled key.
